// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with a small return-address stack (RAS).
//
// Next-PC selection, highest priority first:
//   Exception -> EXC_VECTOR
//   Stall     -> hold PC
//   PCSrc     -> ReadData (loaded as is; Link also pushes PCPlus)
//   Return    -> top of stack if non-empty (pop), else PCPlus + underflow
//   default   -> PCPlus
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   Stall        in   1      hold PC and stack
//   Exception    in   1      redirect to EXC_VECTOR, empties the stack
//   PCSrc        in   1      redirect to ReadData
//   ReadData     in   WIDTH  branch / call target
//   Link         in   1      push return address (only with PCSrc)
//   Return       in   1      pop and redirect (only without PCSrc)
//   PC           out  WIDTH  current fetch address (registered)
//   PCPlus       out  WIDTH  PC + INC, combinational from PC
//   RasEmpty     out  1      stack count is 0
//   RasFull      out  1      stack count is RAS_DEPTH
//   RasUnderflow out  1      one-cycle pulse after a Return on empty stack
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(8),
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             Exception,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] ReadData,
    input  logic             Link,
    input  logic             Return,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasUnderflow
);

    localparam int             TW       = $clog2(RAS_DEPTH);
    localparam int             CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [TW-1:0]  TOP_LAST = TW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [TW-1:0]    r_top;       // index of the most recently pushed entry
    logic [CW-1:0]    r_count;
    logic             r_underflow;

    logic             w_active;
    logic             w_push;
    logic             w_ret;
    logic             w_pop;
    logic             w_underflow;
    logic [TW-1:0]    w_top_inc;
    logic [TW-1:0]    w_top_dec;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_pc_next;

    assign w_pc_plus   = r_pc + WIDTH'(INC);
    assign w_active    = !Exception && !Stall;
    assign w_push      = w_active && PCSrc && Link;
    assign w_ret       = w_active && !PCSrc && Return;
    assign w_pop       = w_ret && (r_count != '0);
    assign w_underflow = w_ret && (r_count == '0);

    // Explicit wrap so non-power-of-two depths stay circular.
    assign w_top_inc = (r_top == TOP_LAST) ? '0 : r_top + TW'(1);
    assign w_top_dec = (r_top == '0) ? TOP_LAST : r_top - TW'(1);

    always_comb begin
        w_pc_next = w_pc_plus;
        if (Exception) begin
            w_pc_next = EXC_VECTOR;
        end else if (Stall) begin
            w_pc_next = r_pc;
        end else if (PCSrc) begin
            w_pc_next = ReadData;
        end else if (w_pop) begin
            w_pc_next = r_stack[r_top];
        end
    end

    // Stack entries carry no reset: they are only read while count > 0,
    // and every counted entry was written by a push after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_top       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_underflow <= w_underflow;
            if (Exception) begin
                r_count <= '0;
            end else if (w_push) begin
                // When full, top+1 is the oldest entry, so it gets overwritten.
                r_stack[w_top_inc] <= w_pc_plus;
                r_top              <= w_top_inc;
                if (r_count != CNT_FULL) begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign PC           = r_pc;
    assign PCPlus       = w_pc_plus;
    assign RasEmpty     = (r_count == '0);
    assign RasFull      = (r_count == CNT_FULL);
    assign RasUnderflow = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        Stall;
  logic        Exception;
  logic        PCSrc;
  logic [31:0] ReadData;
  logic        Link;
  logic        Return;
  logic [31:0] PC;
  logic [31:0] PCPlus;
  logic        RasEmpty;
  logic        RasFull;
  logic        RasUnderflow;

  pc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Stall        (Stall),
    .Exception    (Exception),
    .PCSrc        (PCSrc),
    .ReadData     (ReadData),
    .Link         (Link),
    .Return       (Return),
    .PC           (PC),
    .PCPlus       (PCPlus),
    .RasEmpty     (RasEmpty),
    .RasFull      (RasFull),
    .RasUnderflow (RasUnderflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The stack is a queue: back = youngest; a push onto a full stack drops the front.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_uf;

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_uf = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (Exception) begin
        m_pc = 32'h8;
        m_ras.delete();
        m_uf = 1'b0;
      end else if (Stall) begin
        m_uf = 1'b0;
      end else if (PCSrc) begin
        if (Link) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(m_pc + 32'd4);
        end
        m_pc = ReadData;
        m_uf = 1'b0;
      end else if (Return && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        m_uf = 1'b0;
      end else begin
        m_uf = Return;
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("pc",        PC,                 m_pc);
      check("pcplus",    PCPlus,             m_pc + 32'd4);
      check("ras_empty", {31'b0, RasEmpty},  {31'b0, m_ras.size() == 0});
      check("ras_full",  {31'b0, RasFull},   {31'b0, m_ras.size() == DEPTH});
      check("underflow", {31'b0, RasUnderflow}, {31'b0, m_uf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic ex, input logic src,
                       input logic [31:0] rd, input logic lk, input logic rt);
    Stall = st; Exception = ex; PCSrc = src; ReadData = rd; Link = lk; Return = rt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 0);
  endtask

  // Apply current inputs for one edge; returns at the following negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic run_idle(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic call(input logic [31:0] tgt);
    drive(0, 0, 1, tgt, 1, 0);
    step();
  endtask

  task automatic ret();
    drive(0, 0, 0, 32'h0, 0, 1);
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    // Reset values
    check("rst_pc",     PC,                32'h0);
    check("rst_pcplus", PCPlus,            32'h4);
    check("rst_empty",  {31'b0, RasEmpty}, 32'h1);
    check("rst_full",   {31'b0, RasFull},  32'h0);
    check("rst_uf",     {31'b0, RasUnderflow}, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Sequential and wrap
    idle();
    step(); check("seq1", PC, 32'h4);
    step(); check("seq2", PC, 32'h8);
    step(); check("seq3", PC, 32'hC);
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(); check("jmp_top", PC, 32'hFFFF_FFFC);
    check("wrap_plus", PCPlus, 32'h0);
    idle();
    step(); check("wrap_pc", PC, 32'h0);

    // Call / return
    do_reset();
    run_idle(4);
    check("at_10", PC, 32'h10);
    call(32'h100);
    check("call_pc", PC, 32'h100);
    check("call_empty", {31'b0, RasEmpty}, 32'h0);
    ret();
    check("ret_pc", PC, 32'h14);
    check("ret_empty", {31'b0, RasEmpty}, 32'h1);

    // Overflow and underflow
    do_reset();
    run_idle(4);
    call(32'h20); call(32'h30); call(32'h40); call(32'h50);
    call(32'h300);
    check("ovf_full", {31'b0, RasFull}, 32'h1);
    ret(); check("pop1", PC, 32'h54);
    ret(); check("pop2", PC, 32'h44);
    ret(); check("pop3", PC, 32'h34);
    ret(); check("pop4", PC, 32'h24);
    check("pop_empty", {31'b0, RasEmpty}, 32'h1);
    ret(); check("uf_pc", PC, 32'h28);
    check("uf_pulse", {31'b0, RasUnderflow}, 32'h1);
    idle();
    step(); check("uf_clear", {31'b0, RasUnderflow}, 32'h0);

    // Priority
    do_reset();
    call(32'h80);
    drive(1, 1, 1, 32'h400, 1, 1);
    step();
    check("exc_pc", PC, 32'h8);
    check("exc_empty", {31'b0, RasEmpty}, 32'h1);
    drive(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", PC, 32'h8);
    end

    // Qualifiers
    do_reset();
    call(32'h40);
    drive(0, 0, 0, 32'h0, 1, 0);
    step();
    check("link_ign_pc", PC, 32'h44);
    check("link_ign_empty", {31'b0, RasEmpty}, 32'h0);
    drive(0, 0, 1, 32'h200, 0, 1);
    step();
    check("ret_ign_pc", PC, 32'h200);
    ret();
    check("nopop_pc", PC, 32'h4);
    check("nopop_empty", {31'b0, RasEmpty}, 32'h1);

    // Async reset between edges with two entries stacked
    do_reset();
    call(32'h100);
    call(32'h200);
    check("pre_rst_empty", {31'b0, RasEmpty}, 32'h0);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_pc",    PC,                32'h0);
    check("async_empty", {31'b0, RasEmpty}, 32'h1);
    check("async_plus",  PCPlus,            32'h4);
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 5) == 0,
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 255), 2'b00} : $urandom,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0);
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters SHALL be, one per line, as name, default and meaning:
- WIDTH, 32: PC and target width in bits.
- INC, 4: sequential increment in bytes.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- EXC_VECTOR, 32'h0000_0008: PC value loaded on exception.
- RAS_DEPTH, 4: return-address stack entries, at least 2.

REQ-002 The clock and reset SHALL be a single clock and an asynchronous active-low reset. Ports SHALL be, one per line, as name, direction, width and meaning:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- Stall, in, 1: hold PC and stack.
- Exception, in, 1: redirect to EXC_VECTOR.
- PCSrc, in, 1: redirect to ReadData.
- ReadData, in, WIDTH: branch target.
- Link, in, 1: push return address; qualified by PCSrc.
- Return, in, 1: pop stack and redirect; qualified by !PCSrc.
- PC, out, WIDTH: current fetch address, registered.
- PCPlus, out, WIDTH: PC+INC, combinational from PC.
- RasEmpty, out, 1: stack count is 0.
- RasFull, out, 1: stack count equals RAS_DEPTH.
- RasUnderflow, out, 1: registered one-cycle pulse.

Function
REQ-003 The next PC SHALL be selected by strict priority:
- Exception gives EXC_VECTOR.
- Else Stall holds PC.
- Else PCSrc gives ReadData.
- Else Return with a non-empty stack gives the top of stack.
- Else PCPlus.
REQ-004 PC SHALL update only on the rising edge of clk, with a redirect-to-PC latency of 1 cycle.
REQ-005 PCPlus SHALL equal (PC+INC) mod 2^WIDTH, so that 32'hFFFF_FFFC wraps to 32'h0000_0000 at INC=4.
REQ-006 ReadData SHALL be loaded unmodified, with no alignment masking.
REQ-007 The stack SHALL be a circular buffer of RAS_DEPTH WIDTH-bit entries, with a top pointer and a count from 0 to RAS_DEPTH.
REQ-008 Push SHALL occur when Link=1, PCSrc=1, Stall=0 and Exception=0; the pushed value SHALL be PCPlus of the current cycle.
REQ-009 A push when full SHALL overwrite the oldest entry, advance the top pointer modulo RAS_DEPTH, and hold count at RAS_DEPTH.
REQ-010 Pop SHALL occur when Return=1, PCSrc=0, Stall=0, Exception=0 and count>0; count SHALL decrement and the top pointer SHALL retreat modulo RAS_DEPTH.
REQ-011 Return with count=0 under the REQ-010 qualifiers SHALL:
- select PCPlus;
- leave the stack unchanged;
- drive RasUnderflow=1 for exactly the next cycle.
REQ-012 Link with PCSrc=0 SHALL be ignored.
REQ-013 Return with PCSrc=1 SHALL be ignored, with no pop.
REQ-014 Stall=1 with Exception=0 SHALL freeze PC, the stack pointer, count and entries, and SHALL drive RasUnderflow=0 the next cycle.
REQ-015 Exception SHALL override Stall, PCSrc, Link and Return, and SHALL clear count to 0 on the same edge.
REQ-016 RasEmpty and RasFull SHALL be combinational decodes of count.
REQ-017 All state SHALL be updated from one clocked process.
REQ-018 There SHALL be no combinational path from any input to PC or RasUnderflow.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously force:
- PC to RESET_VECTOR;
- count to 0 and the top pointer to 0;
- RasUnderflow to 0.
REQ-020 Stack entry contents SHALL need no reset and SHALL never be observable while count=0.
REQ-021 Immediately after reset, the outputs SHALL be:
- PCPlus = RESET_VECTOR+INC;
- RasEmpty = 1;
- RasFull = 0.
REQ-022 Reset deassertion SHALL take effect at the first following rising edge.
REQ-023 Reset asserted mid-operation SHALL discard any redirect or push in progress.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios, with defaults and each stimulus applied from reset:
- Sequential and wrap: 3 idle cycles give PC 0, 4, 8, 12. Forcing PC to 32'hFFFF_FFFC via PCSrc gives next PC 0.
- Call/return: at PC=32'h10, PCSrc=1, Link=1, ReadData=32'h100. PC becomes 32'h100 and RasEmpty becomes 0. Then Return=1 gives PC 32'h14 and RasEmpty=1.
- Overflow: 5 calls from PCs 32'h10, 32'h20, 32'h30, 32'h40, 32'h50 give RasFull=1. Then 4 returns give PCs 32'h54, 32'h44, 32'h34, 32'h24. A 5th return gives PCPlus, and RasUnderflow pulses for 1 cycle.
- Priority: Exception=1 with Stall=1, PCSrc=1 and Return=1 gives PC 32'h8 and count 0. Stall=1 alone holds PC for N cycles.
- Qualifiers: Link=1 with PCSrc=0 leaves count unchanged. Return=1 with PCSrc=1 and ReadData=32'h200 gives PC 32'h200 with no pop.
- Async reset: rst_n pulled low between edges with 2 entries stacked forces PC to 0 and RasEmpty to 1 before the next edge.
